// File: rtl/regfile_pkg.sv
// Shared constants, types and address helper for the windowed register file.
package regfile_pkg;

   localparam int DEF_DW      = 32;
   localparam int DEF_DEPTH   = 128;
   localparam int DEF_NUM_OUT = 5;
   localparam int DEF_AW      = $clog2(DEF_DEPTH);

   typedef logic [DEF_AW-1:0] addr_t;
   typedef logic [DEF_DW-1:0] word_t;

   // (base + k) mod DEPTH for the default geometry; k is expected non-negative.
   function automatic addr_t wrap_add(addr_t base, int k);
      return addr_t'((int'(base) + k) % DEF_DEPTH);
   endfunction

endpackage

// File: rtl/regfile_window_lane.sv
// One output lane of the read window: selects a stored word, or the word being
// written this cycle when the lane address collides with the write address.
module regfile_window_lane
   import regfile_pkg::*;
#(
   parameter int  DW    = DEF_DW,
   parameter int  DEPTH = DEF_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic [DW-1:0] mem [DEPTH],
   input  logic [AW-1:0] lane_addr,
   input  logic          wr_hit,
   input  logic [DW-1:0] wr_data,
   output logic [DW-1:0] lane_data
);

   // Write-first: a same-cycle write to this lane's address wins over storage.
   always_comb begin
      lane_data = wr_hit ? wr_data : mem[lane_addr];
   end

endmodule

// File: rtl/regfile_window.sv
// Register file with auto-incrementing burst write and a registered
// NUM_OUT-word read window that wraps modulo DEPTH.
module regfile_window
   import regfile_pkg::*;
#(
   parameter int  DW      = DEF_DW,
   parameter int  DEPTH   = DEF_DEPTH,
   parameter int  NUM_OUT = DEF_NUM_OUT,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  wr_valid,
   input  logic                  wr_first,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DW-1:0]         wr_data,
   input  logic                  rd_req,
   input  logic [AW-1:0]         rd_addr,
   output logic [NUM_OUT*DW-1:0] rd_data,
   output logic                  rd_valid,
   output logic [AW-1:0]         wr_ptr
);

   logic [DW-1:0]         mem [DEPTH];
   logic [AW-1:0]         wr_target;
   logic                  wr_en;
   logic [NUM_OUT*DW-1:0] rd_next;

   // Burst start address overrides the running pointer only on the first word.
   always_comb begin
      wr_en     = en & wr_valid;
      wr_target = wr_first ? wr_addr : wr_ptr;
   end

   // Storage: cleared on reset, one word written per enabled strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_target] <= wr_data;
      end
   end

   // Write pointer follows the last written address; wraps silently in AW bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_target + AW'(1);
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
      logic [AW-1:0] lane_addr;
      logic          wr_hit;

      // Lane address wraps naturally because DEPTH is a power of two.
      always_comb begin
         lane_addr = rd_addr + AW'(k);
         wr_hit    = wr_en && (lane_addr == wr_target);
      end

      regfile_window_lane #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_lane (
         .mem       (mem),
         .lane_addr (lane_addr),
         .wr_hit    (wr_hit),
         .wr_data   (wr_data),
         .lane_data (rd_next[k*DW +: DW])
      );
   end

   // Output window: cleared when disabled, loaded on a read, held when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (!en) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else if (rd_req) begin
         rd_data  <= rd_next;
         rd_valid <= 1'b1;
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_window.sv
// Directed bench for regfile_window: a reference memory model predicts every
// read window at drive time and queues it; windows are popped when rd_valid rises.
module tb_regfile_window;
   import regfile_pkg::*;

   localparam int DW    = DEF_DW;
   localparam int DEPTH = DEF_DEPTH;
   localparam int NO    = DEF_NUM_OUT;

   typedef logic [NO*DW-1:0] win_t;

   logic  clk      = 1'b0;
   logic  rst      = 1'b0;
   logic  en       = 1'b0;
   logic  wr_valid = 1'b0;
   logic  wr_first = 1'b0;
   addr_t wr_addr  = '0;
   word_t wr_data  = '0;
   logic  rd_req   = 1'b0;
   addr_t rd_addr  = '0;
   win_t  rd_data;
   logic  rd_valid;
   addr_t wr_ptr;

   int checks = 0;
   int errors = 0;

   word_t m_mem [DEPTH];
   addr_t m_ptr;
   win_t  m_held;
   win_t  sb [$];

   regfile_window #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .NUM_OUT (NO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .wr_valid (wr_valid),
      .wr_first (wr_first),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_ptr   (wr_ptr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_addr(input string tag, input addr_t obs, input addr_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input word_t obs, input word_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_win(input string tag, input win_t obs, input win_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_ptr  = '0;
      m_held = '0;
      sb.delete();
   endtask

   // One clock of stimulus; predicts, advances a clock, then checks.
   task automatic cycle(input logic e, input logic wv, input logic wf, input addr_t wa,
                        input word_t wd, input logic rr, input addr_t ra);
      addr_t a;
      addr_t la;
      logic  w;
      win_t  win;
      win_t  exp_win;
      en = e; wr_valid = wv; wr_first = wf; wr_addr = wa; wr_data = wd;
      rd_req = rr; rd_addr = ra;
      a   = wf ? wa : m_ptr;
      w   = e & wv;
      win = '0;
      for (int k = 0; k < NO; k++) begin
         la = wrap_add(ra, k);
         win[k*DW +: DW] = (w && la == a) ? wd : m_mem[la];
      end
      if (e && rr) sb.push_back(win);
      @(posedge clk);
      #1;
      if (w) begin
         m_mem[a] = wd;
         m_ptr    = wrap_add(a, 1);
      end
      if (!e) m_held = '0;
      else if (rr) m_held = win;
      chk_bit("rd_valid", rd_valid, e && rr);
      chk_addr("wr_ptr", wr_ptr, m_ptr);
      if (rd_valid === 1'b1) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow: observed rd_valid=1 expected no pending read");
         end
         if (sb.size() != 0) begin
            exp_win = sb.pop_front();
            chk_win("rd_window", rd_data, exp_win);
         end
      end
      chk_win("rd_data_state", rd_data, m_held);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b0;
      #1;
      chk_win("reset_rd_data", rd_data, '0);
      chk_bit("reset_rd_valid", rd_valid, 1'b0);
      chk_addr("reset_wr_ptr", wr_ptr, '0);
      model_clear();
      en = 1'b0; wr_valid = 1'b0; wr_first = 1'b0; rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      model_clear();
      #3;
      chk_win("por_rd_data", rd_data, '0);
      chk_bit("por_rd_valid", rd_valid, 1'b0);
      chk_addr("por_wr_ptr", wr_ptr, '0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Burst of five words starting at 10, then read the window back.
      cycle(1'b1, 1'b1, 1'b1, 7'd10, 32'hA0, 1'b0, '0);
      for (int i = 1; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0, word_t'(32'hA0 + i), 1'b0, '0);
      chk_addr("burst_ptr", wr_ptr, 7'd15);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd10);
      chk_word("burst_lane4", rd_data[4*DW +: DW], 32'hA4);

      // Idle with en high: window holds, rd_valid low.
      idle(3);

      // Wrapping burst and wrapping read window.
      cycle(1'b1, 1'b1, 1'b1, 7'd126, 32'h11, 1'b0, '0);
      for (int i = 1; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, '0, word_t'(32'h11 + i), 1'b0, '0);
      chk_addr("wrap_ptr", wr_ptr, 7'd3);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd126);
      chk_word("wrap_lane2", rd_data[2*DW +: DW], 32'h13);

      // Write-first bypass, then back-to-back reads.
      cycle(1'b1, 1'b1, 1'b1, 7'd20, 32'h5, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, 7'd22, 32'h77, 1'b1, 7'd20);
      chk_word("bypass_lane2", rd_data[2*DW +: DW], 32'h77);
      chk_word("bypass_lane0", rd_data[0 +: DW], 32'h5);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd20);
      chk_word("after_bypass_lane2", rd_data[2*DW +: DW], 32'h77);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd126);
      // Bypass through the running pointer (no wr_first) hitting a read lane.
      cycle(1'b1, 1'b1, 1'b0, '0, 32'h99, 1'b1, 7'd21);

      // Disabled cycle: no write, no read, outputs cleared.
      cycle(1'b0, 1'b1, 1'b1, 7'd30, 32'hFF, 1'b1, 7'd30);
      chk_win("disabled_rd_data", rd_data, '0);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd30);
      chk_word("disabled_no_write", rd_data[0 +: DW], 32'h0);

      // wr_first without wr_valid is ignored.
      cycle(1'b1, 1'b0, 1'b1, 7'd50, 32'h1234, 1'b0, '0);

      // Reset in the middle of a burst.
      cycle(1'b1, 1'b1, 1'b1, 7'd40, 32'hC0, 1'b1, 7'd10);
      cycle(1'b1, 1'b1, 1'b0, '0, 32'hC1, 1'b0, '0);
      async_reset();
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd0);
      chk_win("post_reset_window", rd_data, '0);
      cycle(1'b1, 1'b1, 1'b0, '0, 32'hBB, 1'b0, '0);
      chk_addr("post_reset_ptr", wr_ptr, 7'd1);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd0);
      chk_word("post_reset_lane0", rd_data[0 +: DW], 32'hBB);
      cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 7'd40);
      chk_word("discarded_burst", rd_data[0 +: DW], 32'h0);
      idle(1);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover: observed %0d pending reads expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
